// File: rtl/denise_pkg.sv
// rtl/denise_pkg.sv - shared HAM codes, RGB field offsets and delay-line entry type
package denise_pkg;

    localparam logic [1:0] HAM_CLUT = 2'b00;
    localparam logic [1:0] HAM_B    = 2'b01;
    localparam logic [1:0] HAM_R    = 2'b10;
    localparam logic [1:0] HAM_G    = 2'b11;

    localparam int R_MSB = 23;
    localparam int R_LSB = 16;
    localparam int G_MSB = 15;
    localparam int G_LSB = 8;
    localparam int B_MSB = 7;
    localparam int B_LSB = 0;

    typedef struct packed {
        logic [1:0] ctl;
        logic [5:0] dat;
        logic       en;
        logic       de;
        logic       ham_en;
        logic       ham8;
    } ham_entry_t;

endpackage

// File: rtl/denise_ham_delay.sv
// rtl/denise_ham_delay.sv - DEPTH-stage shift register aligning pixel control with the colour-table read
module denise_ham_delay
    import denise_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  ham_entry_t d,
    output ham_entry_t q
);

    ham_entry_t r_stage [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign q = r_stage[DEPTH-1];

endmodule

// File: rtl/denise_ham_modifier.sv
// rtl/denise_ham_modifier.sv - colour-table address remap and HAM6/HAM8 hold-and-modify output stage
module denise_ham_modifier
    import denise_pkg::*;
#(
    parameter int CLUT_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  pix_sel,
    input  logic        pix_en,
    input  logic        de,
    input  logic        ham_en,
    input  logic        ham8,
    output logic [7:0]  clut_sel,
    input  logic [23:0] clut_rgb,
    output logic [23:0] rgb_out,
    output logic        rgb_valid
);

    ham_entry_t  w_entry;
    ham_entry_t  w_q;
    logic [7:0]  w_held_comp;
    logic [7:0]  w_new_comp;
    logic [23:0] w_result;
    logic [23:0] r_held;
    logic        r_valid;

    always_comb begin
        clut_sel = pix_sel;
        if (ham_en && ham8) begin
            clut_sel = {2'b00, pix_sel[7:2]};
        end else if (ham_en) begin
            clut_sel = {4'h0, pix_sel[3:0]};
        end
    end

    always_comb begin
        w_entry        = '0;
        w_entry.ctl    = ham8 ? pix_sel[1:0] : pix_sel[5:4];
        w_entry.dat    = ham8 ? pix_sel[7:2] : {pix_sel[3:0], 2'b00};
        w_entry.en     = pix_en;
        w_entry.de     = de;
        w_entry.ham_en = ham_en;
        w_entry.ham8   = ham8;
    end

    denise_ham_delay #(
        .DEPTH (CLUT_LAT)
    ) u_delay (
        .clk   (clk),
        .reset (reset),
        .d     (w_entry),
        .q     (w_q)
    );

    // The output register doubles as the held colour: both update on the same edge with the same value.
    always_comb begin
        case (w_q.ctl)
            HAM_B:   w_held_comp = r_held[B_MSB:B_LSB];
            HAM_R:   w_held_comp = r_held[R_MSB:R_LSB];
            HAM_G:   w_held_comp = r_held[G_MSB:G_LSB];
            default: w_held_comp = 8'h00;
        endcase
        w_new_comp = w_q.ham8 ? {w_q.dat, w_held_comp[1:0]} : {w_q.dat[5:2], w_q.dat[5:2]};

        w_result = clut_rgb;
        if (w_q.de && w_q.ham_en) begin
            case (w_q.ctl)
                HAM_B:   w_result = {r_held[R_MSB:G_LSB], w_new_comp};
                HAM_R:   w_result = {w_new_comp, r_held[G_MSB:B_LSB]};
                HAM_G:   w_result = {r_held[R_MSB:R_LSB], w_new_comp, r_held[B_MSB:B_LSB]};
                default: w_result = clut_rgb;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_held  <= 24'h000000;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_q.en;
            if (w_q.en) begin
                r_held <= w_result;
            end
        end
    end

    assign rgb_out   = r_held;
    assign rgb_valid = r_valid;

endmodule

// File: tb/tb_denise_ham_modifier.sv
// tb/tb_denise_ham_modifier.sv - vector table, reset, gapped-strobe and random checks against a reference model
module tb_denise_ham_modifier;

    localparam int LAT = 1;

    logic        clk;
    logic        reset;
    logic [7:0]  pix_sel;
    logic        pix_en;
    logic        de;
    logic        ham_en;
    logic        ham8;
    logic [7:0]  clut_sel;
    logic [23:0] clut_rgb;
    logic [23:0] rgb_out;
    logic        rgb_valid;

    denise_ham_modifier #(.CLUT_LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .pix_sel   (pix_sel),
        .pix_en    (pix_en),
        .de        (de),
        .ham_en    (ham_en),
        .ham8      (ham8),
        .clut_sel  (clut_sel),
        .clut_rgb  (clut_rgb),
        .rgb_out   (rgb_out),
        .rgb_valid (rgb_valid)
    );

    typedef struct {
        logic [7:0]  pix;
        logic        de;
        logic        he;
        logic        h8;
        logic [23:0] exp;
    } vec_t;

    typedef struct {
        logic [23:0] rgb;
        int          due;
    } exp_t;

    logic [23:0] clut [256];
    exp_t        q [$];
    vec_t        vecs [12];
    logic [23:0] held_m;
    logic [23:0] prev_rgb;
    int          cyc;
    int          n_checks;
    int          n_fail;
    logic        gap_mode;
    int          last_v;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        clut_rgb <= clut[clut_sel];
    end

    function automatic int model_idx(input logic [7:0] p, input logic he, input logic h8);
        int v;
        v = int'(p);
        if (!he) return v;
        return h8 ? v / 4 : v % 16;
    endfunction

    function automatic logic [23:0] model(input logic [23:0] held, input logic [7:0] p,
                                          input logic d, input logic he, input logic h8);
        int c [3];
        int code;
        int v;
        int which;
        logic [23:0] base;
        base = clut[model_idx(p, he, h8)];
        if (!d || !he) return base;
        code = h8 ? int'(p) % 4 : (int'(p) / 16) % 4;
        v    = h8 ? int'(p) / 4 : int'(p) % 16;
        if (code == 0) return base;
        c[0] = int'(held[23:16]);
        c[1] = int'(held[15:8]);
        c[2] = int'(held[7:0]);
        which = (code == 1) ? 2 : (code == 2) ? 0 : 1;
        c[which] = h8 ? v * 4 + c[which] % 4 : v * 17;
        return {c[0][7:0], c[1][7:0], c[2][7:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    task automatic drive(input logic [7:0] p, input logic d, input logic he, input logic h8,
                         input logic en, input logic use_exp, input logic [23:0] exp);
        logic [23:0] m;
        exp_t e;
        pix_sel = p;
        de      = d;
        ham_en  = he;
        ham8    = h8;
        pix_en  = en;
        #1;
        check("clut_sel", {24'h0, clut_sel}, {24'h0, 8'(model_idx(p, he, h8))});
        if (en && !reset) begin
            m      = model(held_m, p, d, he, h8);
            held_m = m;
            e.rgb  = use_exp ? exp : m;
            e.due  = cyc + 1 + LAT;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (rgb_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("rgb_out", {8'h0, rgb_out}, {8'h0, e.rgb});
                    check("latency", cyc, e.due);
                end
                if (gap_mode) begin
                    if (last_v >= 0) check("valid_spacing", cyc - last_v, 32'd4);
                    last_v = cyc;
                end
            end else begin
                if (q.size() > 0 && q[0].due <= cyc) begin
                    check("missing_valid", 32'd0, 32'd1);
                    void'(q.pop_front());
                end
                if (gap_mode) check("rgb_stable", {8'h0, rgb_out}, {8'h0, prev_rgb});
            end
        end
        prev_rgb = rgb_out;
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        gap_mode = 1'b0;
        last_v   = -1;
        held_m   = 24'h0;
        reset    = 1'b1;
        pix_sel  = 8'h00;
        pix_en   = 1'b0;
        de       = 1'b0;
        ham_en   = 1'b0;
        ham8     = 1'b0;
        for (int i = 0; i < 256; i++) clut[i] = 24'($urandom);
        clut[8'h2A] = 24'h123456;
        clut[8'h05] = 24'h102030;
        clut[8'h06] = 24'h030303;
        clut[8'h00] = 24'h000055;

        vecs[0]  = '{8'h2A, 1'b1, 1'b0, 1'b0, 24'h123456};
        vecs[1]  = '{8'h05, 1'b1, 1'b1, 1'b0, 24'h102030};
        vecs[2]  = '{8'h1A, 1'b1, 1'b1, 1'b0, 24'h1020AA};
        vecs[3]  = '{8'h2C, 1'b1, 1'b1, 1'b0, 24'hCC20AA};
        vecs[4]  = '{8'h33, 1'b1, 1'b1, 1'b0, 24'hCC33AA};
        vecs[5]  = '{8'h18, 1'b1, 1'b1, 1'b1, 24'h030303};
        vecs[6]  = '{8'hFE, 1'b1, 1'b1, 1'b1, 24'hFF0303};
        vecs[7]  = '{8'h01, 1'b1, 1'b1, 1'b1, 24'hFF0303};
        vecs[8]  = '{8'h41, 1'b1, 1'b1, 1'b1, 24'hFF0343};
        vecs[9]  = '{8'hAB, 1'b1, 1'b1, 1'b1, 24'hFFAB43};
        vecs[10] = '{8'h00, 1'b0, 1'b1, 1'b0, 24'h000055};
        vecs[11] = '{8'h2F, 1'b1, 1'b1, 1'b0, 24'hFF0055};

        #2;
        check("reset_rgb_out", {8'h0, rgb_out}, 32'h0);
        check("reset_rgb_valid", {31'h0, rgb_valid}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].pix, vecs[i].de, vecs[i].he, vecs[i].h8, 1'b1, 1'b1, vecs[i].exp);
        end
        repeat (LAT + 2) drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);

        for (int i = 0; i < 6; i++) drive(8'($urandom), 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h0);
        reset = 1'b1;
        #1;
        check("midreset_rgb_out", {8'h0, rgb_out}, 32'h0);
        check("midreset_rgb_valid", {31'h0, rgb_valid}, 32'h0);
        q.delete();
        held_m = 24'h0;
        pix_sel = 8'($urandom);
        pix_en  = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) drive(8'($urandom), 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 24'h0);
        repeat (LAT + 2) drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);

        gap_mode = 1'b1;
        last_v   = -1;
        for (int i = 0; i < 40; i++) begin
            drive(8'($urandom), ($urandom % 8) != 0, 1'b1, 1'b1, 1'b1, 1'b0, 24'h0);
            repeat (3) drive(8'($urandom), 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0);
        end
        gap_mode = 1'b0;

        for (int i = 0; i < 300; i++) begin
            drive(8'($urandom), ($urandom % 8) != 0, 1'($urandom), 1'($urandom),
                  ($urandom % 4) != 0, 1'b0, 24'h0);
        end
        repeat (LAT + 3) drive(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
        check("queue_drained", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
